// File: rtl/axis_pulse_analyzer_ts.sv
// Pulse height analyzer: finds minimum->maximum pairs in a sample stream and emits
// {sample index, height} events, with pile-up rejection and a single back-pressured output slot.
module axis_pulse_analyzer_ts #(
  parameter int    AXIS_TDATA_WIDTH  = 16,
  parameter string AXIS_TDATA_SIGNED = "FALSE",
  parameter int    CNTR_WIDTH        = 16,
  parameter int    TSTAMP_WIDTH      = 32
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 bln_flag,
  input  logic [AXIS_TDATA_WIDTH-1:0]          bln_data,
  input  logic [CNTR_WIDTH-1:0]                cfg_data,
  input  logic [CNTR_WIDTH-1:0]                cfg_rise_max,
  input  logic [AXIS_TDATA_WIDTH-1:0]          min_data,
  input  logic [AXIS_TDATA_WIDTH-1:0]          max_data,
  output logic                                 s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [TSTAMP_WIDTH+AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  output logic [CNTR_WIDTH-1:0]                sts_lost,
  output logic [CNTR_WIDTH-1:0]                sts_pileup
);

  localparam bit IsSigned = (AXIS_TDATA_SIGNED == "TRUE");
  localparam int DW       = AXIS_TDATA_WIDTH;
  localparam int LW       = TSTAMP_WIDTH + CNTR_WIDTH;

  typedef enum logic [1:0] {HOLDOFF, ARMED, RISING} state_t;

  state_t                   state_q, state_d;
  logic [DW-1:0]            prev_q, prev_d, base_q, base_d;
  logic                     risePrev_q, risePrev_d;
  logic [CNTR_WIDTH-1:0]    cntr_q, cntr_d, lost_q, lost_d, pileup_q, pileup_d;
  logic [TSTAMP_WIDTH-1:0]  tstamp_q, tstamp_d, minIdx_q, minIdx_d;
  logic                     mValid_q, mValid_d;
  logic [TSTAMP_WIDTH+DW-1:0] mData_q, mData_d;

  logic                     rise, minEvt, peakEvt, drain, emit;
  logic [TSTAMP_WIDTH-1:0]  prevIdx, riseDiff;
  logic [LW-1:0]            riseWide;
  logic [CNTR_WIDTH-1:0]    riseLen, cntrInc;
  logic [DW-1:0]            height;

  function automatic logic gtFn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (IsSigned) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  function automatic logic geFn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (IsSigned) return $signed(a) >= $signed(b);
    return a >= b;
  endfunction

  // Minimum and peak both refer to the previous accepted sample, so its index is tstamp-1.
  assign rise     = gtFn(s_axis_tdata, prev_q);
  assign minEvt   = ~risePrev_q & rise;
  assign peakEvt  = risePrev_q & ~rise;
  assign prevIdx  = tstamp_q - TSTAMP_WIDTH'(1);
  assign height   = prev_q - base_q;
  assign riseDiff = prevIdx - minIdx_q;
  assign riseWide = LW'(riseDiff);
  assign riseLen  = (riseWide > LW'({CNTR_WIDTH{1'b1}})) ? {CNTR_WIDTH{1'b1}} : riseWide[CNTR_WIDTH-1:0];
  assign cntrInc  = cntr_q + CNTR_WIDTH'(1);
  assign drain    = mValid_q & m_axis_tready;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    base_d     = base_q;
    risePrev_d = risePrev_q;
    cntr_d     = cntr_q;
    lost_d     = lost_q;
    pileup_d   = pileup_q;
    tstamp_d   = tstamp_q;
    minIdx_d   = minIdx_q;
    mValid_d   = mValid_q;
    mData_d    = mData_q;
    emit       = 1'b0;

    if (drain) begin
      mValid_d = 1'b0;
      mData_d  = '0;
    end

    if (s_axis_tvalid) begin
      tstamp_d   = tstamp_q + TSTAMP_WIDTH'(1);
      prev_d     = s_axis_tdata;
      risePrev_d = rise;
      case (state_q)
        HOLDOFF: begin
          if (cntr_q < cfg_data) begin
            cntr_d = cntrInc;
            if (cntrInc >= cfg_data) state_d = ARMED;
          end else begin
            state_d = ARMED;
          end
        end
        ARMED, RISING: begin
          if (minEvt) begin
            base_d   = bln_flag ? prev_q : bln_data;
            minIdx_d = prevIdx;
            state_d  = RISING;
          end else if (state_q == RISING && peakEvt && gtFn(height, min_data)) begin
            cntr_d  = '0;
            state_d = HOLDOFF;
            if (cfg_rise_max != '0 && riseLen > cfg_rise_max) begin
              if (pileup_q != {CNTR_WIDTH{1'b1}}) pileup_d = pileup_q + CNTR_WIDTH'(1);
            end else if (!geFn(prev_q, max_data)) begin
              emit = 1'b1;
            end
          end
        end
        default: state_d = HOLDOFF;
      endcase
    end

    // A draining slot can accept a new event in the same cycle.
    if (emit) begin
      if (!mValid_q || drain) begin
        mValid_d = 1'b1;
        mData_d  = {prevIdx, height};
      end else if (lost_q != {CNTR_WIDTH{1'b1}}) begin
        lost_d = lost_q + CNTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= HOLDOFF;
      prev_q     <= '0;
      base_q     <= '0;
      risePrev_q <= 1'b0;
      cntr_q     <= '0;
      lost_q     <= '0;
      pileup_q   <= '0;
      tstamp_q   <= '0;
      minIdx_q   <= '0;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      base_q     <= base_d;
      risePrev_q <= risePrev_d;
      cntr_q     <= cntr_d;
      lost_q     <= lost_d;
      pileup_q   <= pileup_d;
      tstamp_q   <= tstamp_d;
      minIdx_q   <= minIdx_d;
      mValid_q   <= mValid_d;
      mData_q    <= mData_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = mValid_q;
  assign m_axis_tdata  = mData_q;
  assign sts_lost      = lost_q;
  assign sts_pileup    = pileup_q;

endmodule

// File: tb/tb_axis_pulse_analyzer_ts.sv
// Directed bench for axis_pulse_analyzer_ts: an unsigned and a signed instance, with
// expected events queued as pulses are driven and popped when a beat is handshaken.
module tb_axis_pulse_analyzer_ts;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [15:0] cfgData, riseMax, minData, maxData;
  logic        mTready;

  logic        uBlnFlag, uTvalid, uTready, uMValid;
  logic [15:0] uBlnData, uTdata, uLost, uPileup;
  logic [47:0] uMData;
  logic        sBlnFlag, sTvalid, sTready, sMValid;
  logic [15:0] sBlnData, sTdata, sLost, sPileup;
  logic [47:0] sMData;

  logic [47:0] uExpQ[$];
  logic [47:0] sExpQ[$];
  int errors = 0;
  int checks = 0;

  axis_pulse_analyzer_ts uDut (
    .aclk(aclk), .aresetn(aresetn), .bln_flag(uBlnFlag), .bln_data(uBlnData),
    .cfg_data(cfgData), .cfg_rise_max(riseMax), .min_data(minData), .max_data(maxData),
    .s_axis_tready(uTready), .s_axis_tdata(uTdata), .s_axis_tvalid(uTvalid),
    .m_axis_tready(mTready), .m_axis_tdata(uMData), .m_axis_tvalid(uMValid),
    .sts_lost(uLost), .sts_pileup(uPileup)
  );

  axis_pulse_analyzer_ts #(.AXIS_TDATA_SIGNED("TRUE")) sDut (
    .aclk(aclk), .aresetn(aresetn), .bln_flag(sBlnFlag), .bln_data(sBlnData),
    .cfg_data(cfgData), .cfg_rise_max(riseMax), .min_data(minData), .max_data(maxData),
    .s_axis_tready(sTready), .s_axis_tdata(sTdata), .s_axis_tvalid(sTvalid),
    .m_axis_tready(mTready), .m_axis_tdata(sMData), .m_axis_tvalid(sMValid),
    .sts_lost(sLost), .sts_pileup(sPileup)
  );

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one sample into the selected instance; returns 2ns after the accepting edge.
  task automatic applyStimulus(input bit sel, input int d);
    if (sel) begin sTvalid = 1'b1; sTdata = d[15:0]; end
    else begin uTvalid = 1'b1; uTdata = d[15:0]; end
    @(posedge aclk); #2;
    uTvalid = 1'b0;
    sTvalid = 1'b0;
  endtask

  task automatic resetDut();
    aresetn = 1'b0;
    uTvalid = 1'b0;
    sTvalid = 1'b0;
    @(posedge aclk); #2;
    checkOutput("rst_u_tvalid", 48'(uMValid), 48'd0);
    checkOutput("rst_u_tdata", uMData, 48'd0);
    checkOutput("rst_u_sts", {16'd0, uLost, uPileup}, 48'd0);
    checkOutput("rst_u_tready", 48'(uTready), 48'd1);
    checkOutput("rst_s_tvalid", {15'd0, sMValid, sMData[31:0]}, 48'd0);
    checkOutput("rst_s_tready", 48'(sTready), 48'd1);
    aresetn = 1'b1;
  endtask

  task automatic syncEdge();
    @(posedge aclk); #2;
  endtask

  always @(negedge aclk) begin
    if (aresetn === 1'b1 && mTready === 1'b1 && uMValid === 1'b1)
      checkOutput("u_beat", uMData, (uExpQ.size() != 0) ? uExpQ.pop_front() : 48'bx);
    if (aresetn === 1'b1 && mTready === 1'b1 && sMValid === 1'b1)
      checkOutput("s_beat", sMData, (sExpQ.size() != 0) ? sExpQ.pop_front() : 48'bx);
  end

  initial begin
    int pulseA[7];
    pulseA = '{9, 6, 10, 14, 18, 22, 5};
    aresetn = 1'b0;
    cfgData = 16'd2; riseMax = 16'd0; minData = 16'd5; maxData = 16'd1000;
    mTready = 1'b1;
    uBlnFlag = 1'b1; uBlnData = 16'd0; uTvalid = 1'b0; uTdata = 16'd0;
    sBlnFlag = 1'b0; sBlnData = 16'd100; sTvalid = 1'b0; sTdata = 16'd0;
    resetDut();

    // Basic event: min 6 at index 2, peak 50 at index 4.
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6);
    applyStimulus(0, 20); applyStimulus(0, 50);
    checkOutput("basic_before", 48'(uMValid), 48'd0);
    uExpQ.push_back({32'd4, 16'd44});
    applyStimulus(0, 30);
    @(negedge aclk);
    checkOutput("basic_latency", 48'(uMValid), 48'd1);
    checkOutput("basic_sts", {16'd0, uLost, uPileup}, 48'd0);
    syncEdge();
    checkOutput("basic_drain", {uMData[46:0], uMValid}, 48'd0);

    // Peak above max_data is discarded; next pulse after hold-off emits.
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6);
    applyStimulus(0, 20); applyStimulus(0, 1200); applyStimulus(0, 30);
    @(negedge aclk);
    checkOutput("maxcut_none", 48'(uMValid), 48'd0);
    syncEdge();
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6);
    applyStimulus(0, 20); applyStimulus(0, 50);
    uExpQ.push_back({32'd16, 16'd44});
    applyStimulus(0, 30);
    @(negedge aclk);
    checkOutput("maxcut_next", 48'(uMValid), 48'd1);
    syncEdge();

    // Pile-up: rise length 4 exceeds 2, then equals 4 and is accepted.
    resetDut();
    riseMax = 16'd2;
    for (int i = 0; i < 7; i++) applyStimulus(0, pulseA[i]);
    @(negedge aclk);
    checkOutput("pileup_none", 48'(uMValid), 48'd0);
    checkOutput("pileup_cnt", {16'd0, uLost, uPileup}, 48'd1);
    syncEdge();
    resetDut();
    riseMax = 16'd4;
    for (int i = 0; i < 6; i++) applyStimulus(0, pulseA[i]);
    uExpQ.push_back({32'd5, 16'd16});
    applyStimulus(0, pulseA[6]);
    @(negedge aclk);
    checkOutput("pileup_edge", 48'(uMValid), 48'd1);
    syncEdge();

    // Back-pressure: first event held, second dropped.
    resetDut();
    riseMax = 16'd0;
    mTready = 1'b0;
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6);
    applyStimulus(0, 20); applyStimulus(0, 50); applyStimulus(0, 30);
    uExpQ.push_back({32'd4, 16'd44});
    @(negedge aclk);
    checkOutput("bp_first", uMData, {32'd4, 16'd44});
    syncEdge();
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6);
    applyStimulus(0, 20); applyStimulus(0, 60); applyStimulus(0, 30);
    @(negedge aclk);
    checkOutput("bp_hold", {uMValid, uMData[46:0]}, {1'b1, 15'd0, 16'd4, 16'd44});
    checkOutput("bp_lost", {16'd0, uLost, uPileup}, {16'd0, 16'd1, 16'd0});
    syncEdge();
    mTready = 1'b1;
    syncEdge();
    mTready = 1'b0;
    checkOutput("bp_release", {uMData[46:0], uMValid}, 48'd0);
    mTready = 1'b1;

    // Signed baseline mode, then a negative-height peak that must be ignored.
    resetDut();
    applyStimulus(1, -40); applyStimulus(1, -50); applyStimulus(1, 120);
    applyStimulus(1, 300);
    sExpQ.push_back({32'd3, 16'd200});
    applyStimulus(1, 250);
    @(negedge aclk);
    checkOutput("signed_evt", 48'(sMValid), 48'd1);
    syncEdge();
    applyStimulus(1, 0); applyStimulus(1, -10); applyStimulus(1, 5); applyStimulus(1, 3);
    @(negedge aclk);
    checkOutput("signed_neg", {sMValid, 15'd0, sPileup, sLost}, 48'd0);
    syncEdge();

    // Reset while RISING discards the pulse and restarts indices.
    resetDut();
    applyStimulus(0, 10); applyStimulus(0, 8); applyStimulus(0, 6); applyStimulus(0, 20);
    resetDut();
    applyStimulus(0, 50); applyStimulus(0, 30);
    @(negedge aclk);
    checkOutput("midrst_none", 48'(uMValid), 48'd0);
    syncEdge();
    applyStimulus(0, 20); applyStimulus(0, 60); applyStimulus(0, 90);
    uExpQ.push_back({32'd4, 16'd70});
    applyStimulus(0, 70);
    @(negedge aclk);
    checkOutput("midrst_idx", 48'(uMValid), 48'd1);
    syncEdge();
    repeat (3) syncEdge();

    checkOutput("u_sb_empty", 48'(uExpQ.size()), 48'd0);
    checkOutput("s_sb_empty", 48'(sExpQ.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pulse_analyzer_ts.md
# axis_pulse_analyzer_ts

Second-generation pulse height analyzer for spectroscopy chains. It sits between the shaping filter output and the histogram/event writer. It finds minimum→maximum pulse pairs and measures each height against either the tracked minimum or an external baseline. It adds three things to the base analyzer:

- a sample-index timestamp on every event;
- pile-up rejection by maximum rise length;
- explicit output back-pressure handling, with saturating status counters for dropped and rejected events.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 16, sample and height width
- AXIS_TDATA_SIGNED, "FALSE", "TRUE" selects signed compares and subtraction
- CNTR_WIDTH, 16, width of the hold-off counter, rise counter and status counters
- TSTAMP_WIDTH, 32, width of the sample-index timestamp

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset: aresetn, synchronous, active-low; clock aclk
- bln_flag  in  1  1 = measure height from the tracked minimum, 0 = from bln_data
- bln_data  in  AXIS_TDATA_WIDTH  external baseline
- cfg_data  in  CNTR_WIDTH  hold-off length in accepted samples
- cfg_rise_max  in  CNTR_WIDTH  maximum allowed rise length; 0 disables pile-up rejection
- min_data  in  AXIS_TDATA_WIDTH  height must be strictly greater than this
- max_data  in  AXIS_TDATA_WIDTH  peak sample must be strictly less than this
- s_axis_tready  out  1  constant 1
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input samples
- s_axis_tvalid  in  1  sample strobe
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  TSTAMP_WIDTH+AXIS_TDATA_WIDTH  {timestamp, height}
- m_axis_tvalid  out  1  event valid
- sts_lost  out  CNTR_WIDTH  events dropped because the output slot was full
- sts_pileup  out  CNTR_WIDTH  events rejected as pile-up

## Operation
- Every sample is "accepted" when s_axis_tvalid=1. Nothing advances on cycles with s_axis_tvalid=0.
- Sample index: a TSTAMP_WIDTH counter that is 0 for the first accepted sample after reset and increments per accepted sample, wrapping modulo 2^TSTAMP_WIDTH.
- Slope tracking: rise = (x > prev), where x is the current sample and prev is the previous accepted sample (0 after reset). rise_prev is the rise value of the previous accepted sample.
  - Minimum event: ~rise_prev & rise; the minimum sample is prev.
  - Peak event: rise_prev & ~rise; the peak sample is prev.
- Comparisons and subtraction are signed or unsigned per AXIS_TDATA_SIGNED. height = peak − base, modulo 2^AXIS_TDATA_WIDTH.
- States (reset state HOLDOFF):
  - HOLDOFF: while cntr < cfg_data, each accepted sample increments cntr. When cntr ≥ cfg_data, go to ARMED on the same evaluation (no extra sample). cfg_data=0 means immediately ARMED.
  - ARMED: on a minimum event:
    - base = bln_flag ? minimum sample : bln_data;
    - record the minimum index;
    - go to RISING.
  - RISING, on a minimum event: update base and the minimum index (re-arm on the new minimum). Stay in RISING.
  - RISING, on a peak event:
    - rise_len = peak index − minimum index, saturating at 2^CNTR_WIDTH−1.
    - If height ≤ min_data: ignore the peak and stay in RISING.
    - Else if cfg_rise_max≠0 and rise_len > cfg_rise_max: increment sts_pileup and emit nothing.
    - Else if peak ≥ max_data: discard silently.
    - Else emit {peak index, height}.
    - In all cases except the ignored one: cntr=0, go to HOLDOFF.
- Output slot (single register):
  - On emit, load the slot if it is empty, or if it is being drained this cycle (m_axis_tvalid & m_axis_tready).
  - Otherwise drop the event and increment sts_lost.
  - The slot clears on m_axis_tvalid & m_axis_tready. m_axis_tdata is all-zero whenever m_axis_tvalid=0.
- Status counters saturate at 2^CNTR_WIDTH−1 and clear only on reset.

## Timing
- Reset:
  - m_axis_tvalid=0, m_axis_tdata=0, sts_lost=0, sts_pileup=0;
  - timestamp, cntr, prev and rise_prev are 0; state is HOLDOFF;
  - s_axis_tready=1 at all times.
- Latency: if the sample after the peak is accepted in cycle m, m_axis_tvalid=1 in cycle m+1.
- Sustained input at 1 sample/cycle is supported. Throughput is limited only by hold-off and the single output slot.
- A reset asserted mid-RISING or with the slot full discards all pending state. No event is emitted afterwards.
- Configuration inputs are sampled on the cycle they are used. Changes take effect on the next accepted sample.

## Test plan
- Basic event (unsigned; cfg_data=2, bln_flag=1, min_data=5, max_data=1000, cfg_rise_max=0):
  - Stimulus: samples 10,8,6,20,50,30 on consecutive cycles, m_axis_tready=1.
  - Response: one beat with tdata={4,44}, tvalid high the cycle after sample 30. sts counters stay 0.
- Max cut: same setup with peak 1200 (max_data=1000).
  - Response: no output. A following pulse 6→20→50→30 after hold-off emits height 44.
- Pile-up (cfg_rise_max=2):
  - Stimulus: samples 9,6,10,14,18,22,5 (indices 0..6).
  - Response: rise_len=4, no output, sts_pileup=1. The same pulse with cfg_rise_max=4 emits {5,16}.
- Back-pressure (m_axis_tready=0): two valid pulses.
  - Response: the first is held stable and the second is dropped, sts_lost=1.
  - Then raise m_axis_tready for one cycle: tvalid and tdata go to 0 the next cycle.
- Signed baseline mode (AXIS_TDATA_SIGNED="TRUE", bln_flag=0, bln_data=100):
  - Stimulus: samples −40,−50,120,300,250.
  - Response: height=200, timestamp 3. A 0→−10 negative excursion followed by 5 gives no event.
- Reset mid-RISING:
  - Stimulus: assert aresetn=0 for 1 cycle after a minimum is detected, then continue the pulse.
  - Response: no event for that pulse. Indices restart at 0. All outputs are 0 during reset.
